fmap_nibble_streamer: RTL and testbench
=======================================

Name: fmap_nibble_streamer

Overview:
- Consumer side of the layer read-port protocol (start/done pulses, read_addr in, 4-bit read_data out).
- Triggers an upstream layer, waits for its done pulse, then reads every element of the upstream feature map through that layer's random-access read port.
- Emits the elements as a valid/ready stream in a selectable flatten order. Sits between the last pooling stage and the dense/classifier stage.

Parameters:
- CH, 64, channel count of upstream map
- H, 8, map height
- W, 8, map width
- DW, 4, element width (bits)
- RD_LAT, 1, cycles from stable up_read_addr to valid up_read_data (≥1)
- ORDER, 0, 0 = CHW flatten (addr sequential); 1 = HWC flatten (channel fastest)

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- start  in  1  one-cycle request to run a full pass; ignored unless IDLE
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when the last element has been accepted downstream
- up_start  out  1  one-cycle start pulse to upstream layer
- up_done  in  1  one-cycle pulse from upstream when its map is ready
- up_read_addr  out  32  element address into upstream map, ch*H*W + r*W + c
- up_read_data  in  DW  upstream element, valid RD_LAT cycles after address stable
- m_valid  out  1  stream element valid
- m_ready  in  1  downstream accept
- m_data  out  DW  stream element
- m_last  out  1  high with final element (index CH*H*W-1)

Behaviour:
- Reset (resetn=0 at clk edge): state IDLE; busy, done, up_start, m_valid, m_last = 0; m_data = 0; up_read_addr = 0; FIFO emptied; counters cleared. Applies mid-pass: the in-flight pass is abandoned, and no done is issued.
- States: IDLE → UPSTART → WAIT_UP → ISSUE → WAIT_DATA → CAPTURE → (ISSUE | DRAIN) → DONE → IDLE.
- IDLE: on start, busy=1, up_start=1 for exactly one cycle (UPSTART), then WAIT_UP.
- up_done is sampled in UPSTART and in WAIT_UP. If seen in either, proceed to ISSUE with element counter k=0.
- ISSUE: drive up_read_addr for element k. Only entered when the output FIFO has at least one free slot.
  - ORDER=0: addr=k.
  - ORDER=1: c_fast = k mod CH, pix = k div CH, addr = c_fast*H*W + pix. Implement with nested ch/pix counters, no divider.
- up_read_addr is held stable from ISSUE through CAPTURE. Upstream muxes data on live address bits, so the address must not change before data is captured.
- WAIT_DATA: counts RD_LAT-1 cycles. CAPTURE: write up_read_data into the FIFO, k=k+1.
- After CAPTURE: if k==CH*H*W, go to DRAIN. Otherwise go to ISSUE when the FIFO is not full; else stall in CAPTURE-hold with the address unchanged.
- Read period is RD_LAT+1 cycles per element when there is no backpressure.
- Output FIFO:
  - 2 entries, DW+1 wide (data plus last flag); last flag set for element CH*H*W-1.
  - m_valid = FIFO not empty; m_data/m_last come from the head. The head is stable while m_valid && !m_ready.
  - Simultaneous push and pop when full is not possible (push is gated by space at ISSUE). Simultaneous push and pop at count 1 leaves count 1.
- DRAIN: wait until the FIFO is empty. DONE: done=1 for one cycle, busy=0, return to IDLE.
- start while busy: ignored, no effect on the pass.
- up_done outside UPSTART/WAIT_UP: ignored.
- Counters sized $clog2(CH*H*W+1). up_read_addr is zero-extended to 32 bits.

Decomposition:
- Shared package (cnn_pkg): state enum fmap_strm_state_t and a localparam function for the element total CH*H*W.
- One sub-module: nibble_fifo2, a 2-entry synchronous FIFO with full/empty flags.
- Address generation and the FSM stay in the top level.

Test Plan:
- Upstream model with mem[i]=i[3:0] and RD_LAT=1; ORDER=0; m_ready=1; pulse start.
  - Response: exactly one up_start pulse.
  - After up_done: m_data sequence 0,1,…,15,0,… for 4096 beats, handshakes every 2 cycles.
  - m_last only on beat 4095; done one cycle after the FIFO empties; busy low afterwards.
- ORDER=1 with mem[a]=a[9:6] (channel low bits).
  - Beat k carries (k mod 64)[3:0]; beat 64 has up_read_addr=1; m_last on beat 4095.
- Random m_ready (30% high), RD_LAT=3.
  - Stream content is identical to test 1; m_data never changes while m_valid && !m_ready.
  - up_read_addr is stable for ≥4 cycles per read.
- up_done returned in the same cycle as up_start.
  - Pass proceeds without hang; first ISSUE occurs the next cycle.
- resetn low for 1 cycle at beat 1000, then new start.
  - All outputs 0 during and after reset; no done for the aborted pass; second pass delivers full 4096 beats from addr 0.
- start pulsed repeatedly mid-pass.
  - Ignored: single up_start, single done, beat count 4096.

Source files
------------

// File: rtl/fmap_nibble_streamer_pkg.sv
// cnn_pkg: shared types and helpers for the feature-map streaming blocks.
//   fmap_strm_state_t : FSM encoding of fmap_nibble_streamer (also exported on
//                       its dbg_state port)
//   fmap_total()      : element count of a CH x H x W feature map
package cnn_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_UPSTART   = 4'd1,
    S_WAIT_UP   = 4'd2,
    S_ISSUE     = 4'd3,
    S_WAIT_DATA = 4'd4,
    S_CAPTURE   = 4'd5,
    S_HOLD      = 4'd6,  // capture done, waiting for a free FIFO slot
    S_DRAIN     = 4'd7,
    S_DONE      = 4'd8
  } fmap_strm_state_t;

  function automatic int fmap_total(input int ch, input int h, input int w);
    return ch * h * w;
  endfunction

endpackage

// File: rtl/fmap_nibble_streamer_fifo2.sv
// nibble_fifo2: two-entry synchronous FIFO.
//   clk, resetn : clock, synchronous active-low reset (clears storage too)
//   push_i/din_i: write request and data (ignored when full)
//   pop_i       : read request (ignored when empty)
//   dout_o      : head entry, stable until popped
//   full_o, empty_o, count_o : occupancy
module nibble_fifo2 #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_q, rd_q;
  logic [1:0]       cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign push_ok = push_i && (cnt_q != 2'd2);
  assign pop_ok  = pop_i && (cnt_q != 2'd0);

  always_comb begin
    cnt_d = cnt_q;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_ok) mem_q[wr_q] <= din_i;
      wr_q  <= wr_q ^ push_ok;
      rd_q  <= rd_q ^ pop_ok;
      cnt_q <= cnt_d;
    end
  end

  assign dout_o  = mem_q[rd_q];
  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign count_o = cnt_q;

endmodule

// File: rtl/fmap_nibble_streamer.sv
// fmap_nibble_streamer: triggers an upstream layer, waits for its done pulse,
// reads the whole CH x H x W map through the upstream random-access read port
// and emits it as a valid/ready stream in CHW (ORDER=0) or HWC (ORDER=1) order.
//   clk, resetn            : clock, synchronous active-low reset
//   start / busy / done    : pass request, pass in progress, end-of-pass pulse
//   up_start / up_done     : trigger and completion pulses of the upstream layer
//   up_read_addr / up_read_data : upstream read port, data RD_LAT cycles after address
//   m_valid/m_ready/m_data/m_last : output stream
//   dbg_state              : current FSM state (fmap_strm_state_t)
//
// Stream handshake: an element transfers on every clock edge where m_valid and
// m_ready are both high; while m_valid is high and m_ready low, m_data and
// m_last hold and m_valid stays high.
module fmap_nibble_streamer
  import cnn_pkg::*;
#(
  parameter int CH     = 64,
  parameter int H      = 8,
  parameter int W      = 8,
  parameter int DW     = 4,
  parameter int RD_LAT = 1,
  parameter int ORDER  = 0
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          up_start,
  input  logic          up_done,
  output logic [31:0]   up_read_addr,
  input  logic [DW-1:0] up_read_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic [3:0]    dbg_state
);

  localparam int TOTAL = fmap_total(CH, H, W);
  localparam int HW    = H * W;
  localparam int KW    = $clog2(TOTAL + 1);
  localparam int CW    = (CH > 1) ? $clog2(CH) : 1;
  localparam int PW    = $clog2(HW + 1);
  localparam int LW    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int AW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  fmap_strm_state_t state_q, state_d;
  logic [KW-1:0]    k_q, k_d;      // elements captured so far
  logic [CW-1:0]    ch_q, ch_d;    // HWC order: channel (fast) index
  logic [PW-1:0]    pix_q, pix_d;  // HWC order: pixel (slow) index
  logic [AW-1:0]    addr_q, addr_d;
  logic [LW-1:0]    lat_q, lat_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [1:0]    fifo_cnt;
  logic [DW:0]   fifo_din, fifo_dout;
  logic          is_last_elem;

  assign is_last_elem = (k_q == KW'(TOTAL - 1));
  assign fifo_push    = (state_q == S_CAPTURE);
  assign fifo_din     = {is_last_elem, up_read_data};
  assign fifo_pop     = m_valid && m_ready;

  nibble_fifo2 #(.WIDTH(DW + 1)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (fifo_push),
    .din_i   (fifo_din),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      ch_q    <= '0;
      pix_q   <= '0;
      addr_q  <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      ch_q    <= ch_d;
      pix_q   <= pix_d;
      addr_q  <= addr_d;
      lat_q   <= lat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    ch_d    = ch_q;
    pix_d   = pix_q;
    addr_d  = addr_q;
    lat_d   = lat_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_UPSTART;
          k_d     = '0;
          ch_d    = '0;
          pix_d   = '0;
          addr_d  = '0;
        end
      end
      S_UPSTART: state_d = up_done ? S_ISSUE : S_WAIT_UP;
      S_WAIT_UP: if (up_done) state_d = S_ISSUE;
      S_ISSUE: begin
        lat_d   = '0;
        state_d = (RD_LAT > 1) ? S_WAIT_DATA : S_CAPTURE;
      end
      S_WAIT_DATA: begin
        if (lat_q == LW'(RD_LAT - 2)) state_d = S_CAPTURE;
        else                          lat_d   = lat_q + LW'(1);
      end
      S_CAPTURE: begin
        k_d = k_q + KW'(1);
        if (is_last_elem) begin
          // Address is left on the final element; nothing further is read.
          state_d = S_DRAIN;
        end else begin
          if (ORDER == 1) begin
            // Channel-fastest walk: step by one channel plane, and on channel
            // wrap move to the next pixel of channel 0.
            if (ch_q == CW'(CH - 1)) begin
              ch_d   = '0;
              pix_d  = pix_q + PW'(1);
              addr_d = AW'(pix_q) + AW'(1);
            end else begin
              ch_d   = ch_q + CW'(1);
              addr_d = addr_q + AW'(HW);
            end
          end else begin
            addr_d = addr_q + AW'(1);
          end
          // The push lands this edge; a slot stays free only if the FIFO was
          // empty or its head is leaving in the same cycle.
          state_d = (fifo_cnt == 2'd0 || fifo_pop) ? S_ISSUE : S_HOLD;
        end
      end
      S_HOLD:  if (!fifo_full) state_d = S_ISSUE;
      S_DRAIN: begin
        if (fifo_empty || (fifo_cnt == 2'd1 && fifo_pop)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done         = (state_q == S_DONE);
  assign up_start     = (state_q == S_UPSTART);
  assign up_read_addr = {{(32 - AW){1'b0}}, addr_q};
  assign m_valid      = !fifo_empty;
  assign m_data       = fifo_dout[DW-1:0];
  assign m_last       = fifo_dout[DW];
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_fmap_nibble_streamer.sv
module tb_fmap_nibble_streamer;
  import cnn_pkg::*;

  localparam int CH    = 64;
  localparam int H     = 8;
  localparam int W     = 8;
  localparam int DW    = 4;
  localparam int TOTAL = CH * H * W;
  localparam int LAT [3] = '{1, 1, 3};
  localparam int ORD [3] = '{0, 1, 0};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn;

  logic          start_s [3];
  logic          busy_s  [3];
  logic          done_s  [3];
  logic          ups_s   [3];
  logic          upd_s   [3];
  logic [31:0]   addr_s  [3];
  logic [DW-1:0] rdd_s   [3];
  logic          mv_s    [3];
  logic          mr_s    [3];
  logic [DW-1:0] md_s    [3];
  logic          ml_s    [3];
  logic [3:0]    dbg_s   [3];
  int            up_dly  [3];

  int errors = 0;
  int checks = 0;
  logic [DW:0] exp_q [$];
  int          exp_addr [TOTAL];

  fmap_nibble_streamer #(.CH(CH), .H(H), .W(W), .DW(DW), .RD_LAT(1), .ORDER(0)) u0 (
    .clk(clk), .resetn(resetn), .start(start_s[0]), .busy(busy_s[0]), .done(done_s[0]),
    .up_start(ups_s[0]), .up_done(upd_s[0]), .up_read_addr(addr_s[0]), .up_read_data(rdd_s[0]),
    .m_valid(mv_s[0]), .m_ready(mr_s[0]), .m_data(md_s[0]), .m_last(ml_s[0]), .dbg_state(dbg_s[0]));
  fmap_nibble_streamer #(.CH(CH), .H(H), .W(W), .DW(DW), .RD_LAT(1), .ORDER(1)) u1 (
    .clk(clk), .resetn(resetn), .start(start_s[1]), .busy(busy_s[1]), .done(done_s[1]),
    .up_start(ups_s[1]), .up_done(upd_s[1]), .up_read_addr(addr_s[1]), .up_read_data(rdd_s[1]),
    .m_valid(mv_s[1]), .m_ready(mr_s[1]), .m_data(md_s[1]), .m_last(ml_s[1]), .dbg_state(dbg_s[1]));
  fmap_nibble_streamer #(.CH(CH), .H(H), .W(W), .DW(DW), .RD_LAT(3), .ORDER(0)) u2 (
    .clk(clk), .resetn(resetn), .start(start_s[2]), .busy(busy_s[2]), .done(done_s[2]),
    .up_start(ups_s[2]), .up_done(upd_s[2]), .up_read_addr(addr_s[2]), .up_read_data(rdd_s[2]),
    .m_valid(mv_s[2]), .m_ready(mr_s[2]), .m_data(md_s[2]), .m_last(ml_s[2]), .dbg_state(dbg_s[2]));

  // Upstream map contents: low address nibble, or channel low bits for instance 1.
  function automatic logic [DW-1:0] mem_val(input int i, input int a);
    logic [31:0] v;
    v = a;
    return (i == 1) ? v[9:6] : v[3:0];
  endfunction

  // ---------------- upstream layer models ----------------
  for (genvar g = 0; g < 3; g++) begin : g_up
    logic [DW-1:0] pipe [4];
    int            cnt;
    always @(posedge clk) begin
      pipe[0] <= mem_val(g, int'(addr_s[g]));
      for (int j = 1; j < 4; j++) pipe[j] <= pipe[j-1];
      if (!resetn)                          cnt <= 0;
      else if (ups_s[g] && up_dly[g] > 0)   cnt <= up_dly[g];
      else if (cnt > 0)                     cnt <= cnt - 1;
    end
    assign upd_s[g] = (up_dly[g] == 0) ? ups_s[g] : (cnt == 1);
    assign rdd_s[g] = pipe[LAT[g] - 1];
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outs(input int i, input string tag);
    chk({tag, "_busy"},  32'(busy_s[i]), 0);
    chk({tag, "_done"},  32'(done_s[i]), 0);
    chk({tag, "_upst"},  32'(ups_s[i]),  0);
    chk({tag, "_valid"}, 32'(mv_s[i]),   0);
    chk({tag, "_last"},  32'(ml_s[i]),   0);
    chk({tag, "_data"},  32'(md_s[i]),   0);
    chk({tag, "_addr"},  addr_s[i],      0);
    chk({tag, "_state"}, 32'(dbg_s[i]),  32'(S_IDLE));
  endtask

  // ---------------- driver: one full (or aborted) pass ----------------
  task automatic run_pass(input int i, input int ready_pct, input int dly,
                          input bit restarts, input int abort_at);
    int cyc, beats, n_ups, n_dones, ups_cyc, last_cyc, prev_beat, run_len, addr_n, done_cyc;
    logic [31:0] prev_addr;
    logic        stall, fin;
    logic [DW:0] prev_head, e;
    // reference stream from the flatten rule
    exp_q.delete();
    for (int k = 0; k < TOTAL; k++) begin
      int a;
      a = (ORD[i] == 0) ? k : (k % CH) * H * W + k / CH;
      exp_addr[k] = a;
      exp_q.push_back({(k == TOTAL - 1), mem_val(i, a)});
    end
    up_dly[i] = dly;
    cyc = 0; beats = 0; n_ups = 0; n_dones = 0; ups_cyc = -10; last_cyc = -10;
    prev_beat = -10; run_len = 0; addr_n = 0; done_cyc = -1;
    prev_addr = 0; stall = 0; fin = 0; prev_head = '0;
    start_s[i] = 1'b1;
    mr_s[i] = ($urandom_range(1, 100) <= ready_pct);
    while (cyc < 60000 && !fin) begin
      @(posedge clk); #1;
      start_s[i] = restarts && (cyc % 300 == 150) && (beats < TOTAL - 16);
      if (ups_s[i]) begin n_ups++; ups_cyc = cyc; end
      if (dly == 0 && cyc == ups_cyc + 1)
        chk("issue_after_updone", 32'(dbg_s[i]), 32'(S_ISSUE));
      if (stall) begin
        chk("stall_valid", 32'(mv_s[i]), 1);
        chk("stall_head", 32'({ml_s[i], md_s[i]}), 32'(prev_head));
      end
      if (busy_s[i]) begin
        if (addr_s[i] !== prev_addr) begin
          chk("addr_hold_len", 32'(run_len >= LAT[i] + 1), 1);
          addr_n++;
          if (addr_n < TOTAL) chk("addr_seq", addr_s[i], 32'(exp_addr[addr_n]));
          else                chk("addr_count", 32'(addr_n), 32'(TOTAL - 1));
          prev_addr = addr_s[i];
          run_len = 1;
        end else begin
          run_len++;
        end
      end
      if (done_s[i]) begin
        n_dones++;
        chk("done_timing", 32'(cyc), 32'(last_cyc + 1));
        chk("busy_at_done", 32'(busy_s[i]), 0);
        done_cyc = cyc;
      end else if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        chk("busy_after_done", 32'(busy_s[i]), 0);
        chk("valid_after_done", 32'(mv_s[i]), 0);
        fin = 1'b1;
      end
      // downstream
      mr_s[i] = ($urandom_range(1, 100) <= ready_pct);
      if (mv_s[i] && mr_s[i]) begin
        if (exp_q.size() == 0) begin
          chk("beat_count", 32'(beats), 32'(TOTAL - 1));
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", 32'(md_s[i]), 32'(e[DW-1:0]));
          chk("beat_last", 32'(ml_s[i]), 32'(e[DW]));
        end
        if (ready_pct == 100 && beats > 0) chk("beat_period", 32'(cyc - prev_beat), 2);
        prev_beat = cyc;
        beats++;
        if (beats == TOTAL) last_cyc = cyc;
      end
      stall = mv_s[i] && !mr_s[i];
      prev_head = {ml_s[i], md_s[i]};
      if (abort_at >= 0 && beats == abort_at) begin
        resetn = 1'b0;
        start_s[i] = 1'b0;
        @(posedge clk); #1;
        chk_idle_outs(i, "abort_rst");
        resetn = 1'b1;
        mr_s[i] = 1'b1;
        for (int c = 0; c < 20; c++) begin
          @(posedge clk); #1;
          chk("abort_no_done", 32'(done_s[i]), 0);
          chk("abort_no_busy", 32'(busy_s[i]), 0);
          chk("abort_no_valid", 32'(mv_s[i]), 0);
        end
        return;
      end
      cyc++;
    end
    mr_s[i] = 1'b0;
    chk("pass_finished", 32'(fin), 1);
    chk("up_start_count", 32'(n_ups), 1);
    chk("done_count", 32'(n_dones), 1);
    chk("beats_total", 32'(beats), 32'(TOTAL));
    chk("reads_total", 32'(addr_n), 32'(TOTAL - 1));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0;
      mr_s[i] = 1'b0;
      up_dly[i] = 3;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) chk_idle_outs(i, "reset");
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_pass(0, 100, 3, 1'b0, -1);   // CHW order, full-rate sink
    run_pass(1, 100, 3, 1'b0, -1);   // HWC order
    run_pass(2, 30, 3, 1'b0, -1);    // RD_LAT=3, sparse ready
    run_pass(0, 100, 0, 1'b0, -1);   // up_done in the same cycle as up_start
    run_pass(0, 100, 3, 1'b0, 1000); // reset in the middle of a pass
    run_pass(0, 100, 3, 1'b0, -1);   // fresh pass after reset
    run_pass(0, 70, 2, 1'b1, -1);    // start pulsed repeatedly mid-pass

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
